// File: rtl/nf_mem_pkg.sv
// Shared types for the common-RAM access controller: FSM states, requester ids
// and the word-index range check used on both address paths.
package nf_mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } nf_ram_arb_st_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } nf_req_id_t;

    // Byte address -> word index, compared against the attached RAM size.
    function automatic logic wordInRange(input logic [31:0] addr, input int unsigned lim);
        return {2'b00, addr[31:2]} < lim;
    endfunction

endpackage

// File: rtl/nf_rr_arb2.sv
// Two-way round-robin selector; bit 0 is the instruction requester, bit 1 the data requester.
// The pointer only moves when both requesters were eligible in the same cycle.
module nf_rr_arb2
    import nf_mem_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] i_eligible,
    output logic [1:0] o_grant,
    output nf_req_id_t o_pointer
);

    nf_req_id_t r_pointer;

    always_comb begin
        o_grant = 2'b00;
        case (i_eligible)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = (r_pointer == REQ_I) ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

    // After a contended grant the loser becomes the preferred requester.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pointer <= REQ_I;
        end else if (&i_eligible) begin
            r_pointer <= (r_pointer == REQ_I) ? REQ_D : REQ_I;
        end
    end

    assign o_pointer = r_pointer;

endmodule

// File: rtl/nf_ram_arb.sv
// Time-shares one single-port RAM between instruction fetch (I) and load/store (D),
// one access per cycle, with registered per-requester read data and rvalid pulses.
module nf_ram_arb
    import nf_mem_pkg::*;
#(
    parameter int unsigned depth = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rd,
    output logic        i_rvalid,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wd,
    output logic        d_ack,
    output logic [31:0] d_rd,
    output logic        d_rvalid,
    output logic [31:0] ram_addr,
    output logic        ram_we,
    output logic [31:0] ram_wd,
    input  logic [31:0] ram_rd
);

    nf_ram_arb_st_t r_state;
    nf_ram_arb_st_t w_stateNext;
    nf_req_id_t     w_pointer;
    logic [1:0]     w_eligible;
    logic [1:0]     w_grant;
    logic           w_iInRange;
    logic           w_dInRange;
    logic [31:0]    r_iRd;
    logic [31:0]    r_dRd;
    logic           r_iRvalid;
    logic           r_dRvalid;
    logic           w_unused;

    assign w_iInRange = wordInRange(i_addr, depth);
    assign w_dInRange = wordInRange(d_addr, depth);

    // A requester is never eligible in its own ack cycle, which lets the other one interleave.
    assign w_eligible = {d_req && (r_state != SERVE_D), i_req && (r_state != SERVE_I)};

    nf_rr_arb2 u_rrArb (
        .clk        (clk),
        .resetn     (resetn),
        .i_eligible (w_eligible),
        .o_grant    (w_grant),
        .o_pointer  (w_pointer)
    );

    always_comb begin
        w_stateNext = IDLE;
        if (w_grant[0]) begin
            w_stateNext = SERVE_I;
        end else if (w_grant[1]) begin
            w_stateNext = SERVE_D;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // RAM port is a pure decode of the state so reset kills ram_we without waiting for an edge.
    always_comb begin
        i_ack    = 1'b0;
        d_ack    = 1'b0;
        ram_addr = 32'h0;
        ram_we   = 1'b0;
        ram_wd   = 32'h0;
        case (r_state)
            SERVE_I: begin
                i_ack    = 1'b1;
                ram_addr = {2'b00, i_addr[31:2]};
            end
            SERVE_D: begin
                d_ack    = 1'b1;
                ram_addr = {2'b00, d_addr[31:2]};
                ram_we   = d_we && w_dInRange;
                ram_wd   = d_wd;
            end
            default: begin
                i_ack = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_iRd     <= 32'h0;
            r_dRd     <= 32'h0;
            r_iRvalid <= 1'b0;
            r_dRvalid <= 1'b0;
        end else begin
            r_iRvalid <= 1'b0;
            r_dRvalid <= 1'b0;
            if (r_state == SERVE_I) begin
                r_iRvalid <= 1'b1;
                r_iRd     <= w_iInRange ? ram_rd : 32'h0;
            end
            if ((r_state == SERVE_D) && !d_we) begin
                r_dRvalid <= 1'b1;
                r_dRd     <= w_dInRange ? ram_rd : 32'h0;
            end
        end
    end

    assign i_rd     = r_iRd;
    assign d_rd     = r_dRd;
    assign i_rvalid = r_iRvalid;
    assign d_rvalid = r_dRvalid;

    // Byte-offset bits are ignored for word-aligned accesses; the pointer is observation only.
    assign w_unused = ^{i_addr[1:0], d_addr[1:0], 1'(w_pointer)};

endmodule

// File: doc/nf_ram_arb.md
# nf_ram_arb

Two-requester access controller for the single-port common RAM. It time-shares one RAM port between the instruction-fetch requester (I) and the load/store requester (D) using round-robin arbitration and a registered req/ack handshake. Read data is returned on a per-requester registered read bus. It sits between the core's fetch and LSU front-ends and the RAM instance.

## Interface
Parameters:
- depth, 64, RAM size in 32-bit words; must match the attached RAM.

Ports:
- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- i_req  in  1  instruction read request; hold with i_addr stable until i_ack
- i_addr  in  32  instruction byte address (word aligned)
- i_ack  out  1  one-cycle pulse: I access performed this cycle
- i_rd  out  32  instruction read data
- i_rvalid  out  1  one-cycle pulse: i_rd valid (cycle after i_ack)
- d_req  in  1  data request; hold d_we/d_addr/d_wd stable until d_ack
- d_we  in  1  1 = write, 0 = read
- d_addr  in  32  data byte address (word aligned)
- d_wd  in  32  write data
- d_ack  out  1  one-cycle pulse: D access performed this cycle
- d_rd  out  32  data read data
- d_rvalid  out  1  one-cycle pulse: d_rd valid (cycle after a D read ack)
- ram_addr  out  32  word index to RAM = {2'b0, granted_addr[31:2]}
- ram_we  out  1  RAM write enable
- ram_wd  out  32  RAM write data
- ram_rd  in  32  RAM combinational read data

## Operation
- FSM states:
  - IDLE: no grant; ram_we = 0; ram_addr = 0.
  - SERVE_I: RAM driven from i_addr; i_ack = 1.
  - SERVE_D: RAM driven from d_addr/d_wd; ram_we = d_we; d_ack = 1.
- Next-state arbitration, evaluated at every edge:
  - The eligible set contains I if i_req = 1 and the current state is not SERVE_I, and D if d_req = 1 and the current state is not SERVE_D.
  - A requester's req is therefore ignored in its own ack cycle, so one requester gets at most one access per 2 cycles.
  - Two requesters can interleave at one access per cycle.
- Selection:
  - Exactly one eligible requester: that requester is granted.
  - Both eligible: the round-robin pointer decides, and the pointer then flips to the other requester.
  - None eligible: IDLE.
- Pointer reset value: I.
- Range check on word index w = addr[31:2]:
  - w ≥ depth on a write: ram_we is suppressed; the ack is still given.
  - w ≥ depth on a read: return data is 32'h0.
- Read capture: at the end of a SERVE cycle for a read, ram_rd (or 0 if out of range) is registered into i_rd/d_rd, and the matching rvalid pulses the next cycle.
- rd registers hold their value until the next read by the same requester.
- D writes never assert d_rvalid and never change d_rd.
- ram_we is decoded combinationally from the state, so it drops as soon as resetn asserts.

## Timing
- Reset values (asserting resetn = 0 clears everything asynchronously):
  - state = IDLE
  - pointer = I
  - i_ack, d_ack, i_rvalid, d_rvalid = 0
  - i_rd, d_rd = 0
  - ram_we = 0, ram_addr = 0, ram_wd = 0
- Request latency: req first high in cycle N (RAM idle) gives ack in cycle N+1 and rvalid in cycle N+2.
- If the other requester holds the port in cycle N+1, the ack moves to cycle N+2.
- Back-to-back with both requesters continuously requesting: the ack sequence is I, D, I, D…; each requester's rvalid follows its own ack by 1 cycle.
- Reset in mid-access:
  - The access is aborted and no ack or rvalid is produced.
  - A write whose SERVE cycle is cut by reset before the edge is not performed.
- Dropping req before the ack is illegal. The behaviour is defined anyway: the requester is no longer eligible and no grant is issued.

## Structure
- Shared package nf_mem_pkg holds:
  - state enum nf_ram_arb_st_t {IDLE, SERVE_I, SERVE_D}
  - requester id enum {REQ_I, REQ_D}
- Sub-module nf_rr_arb2: 2-way round-robin selector with inputs eligible[1:0], outputs grant[1:0] and the pointer register, advanced only on a contended grant.
- Top level holds the FSM, address mux, range check and rd/rvalid registers.

## Test plan
- Reset, then i_req with i_addr = 0x8 while RAM word 2 = 0xDEADBEEF → i_ack in cycle 1, i_rvalid in cycle 2 with i_rd = 0xDEADBEEF.
- D write d_addr = 0x10, d_wd = 0x12345678, then D read of 0x10 → ram_we high only in the first SERVE_D cycle; d_rd = 0x12345678; d_rvalid absent after the write.
- i_req and d_req both held high from reset for 6 accesses → ack order I, D, I, D, I, D; no cycle with both acks.
- Only d_req held high with new addresses each ack → d_ack every other cycle (state alternates SERVE_D/IDLE).
- D write to d_addr = depth*4 → d_ack given, ram_we = 0, RAM unchanged; a D read there returns d_rd = 0.
- resetn pulsed low during a SERVE_D write cycle → ram_we drops immediately, RAM word unchanged, all outputs at reset values, pointer = I.
